// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment scanner: one blank cycle, then SCAN_DIV-1 lit cycles per digit.
// Optional leading-zero suppression when LEADING_ZERO_BLANK_EN is defined.
module display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                                                  clock,
  input  logic                                                  reset,
  input  logic                                                  en,
  input  logic [4*NUM_DIGITS-1:0]                               digits,
  input  logic [NUM_DIGITS-1:0]                                 dp,
  output logic [6:0]                                            seg_L,
  output logic                                                  dp_L,
  output logic [NUM_DIGITS-1:0]                                 an_L,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    cur_nib_q, cur_nib_d;
  logic          cur_dp_q, cur_dp_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic          lz_q, lz_d;
  logic          upper_nz;
`endif

  logic [6:0]            seg_d, seg_dec;
  logic                  dp_ld;
  logic [NUM_DIGITS-1:0] an_d;
  logic [IW-1:0]         didx_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      cur_nib_q <= '0;
      cur_dp_q  <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      lz_q      <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      cur_nib_q <= cur_nib_d;
      cur_dp_q  <= cur_dp_d;
`ifdef LEADING_ZERO_BLANK_EN
      lz_q      <= lz_d;
`endif
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    cur_nib_d = cur_nib_q;
    cur_dp_d  = cur_dp_q;
`ifdef LEADING_ZERO_BLANK_EN
    lz_d      = lz_q;
    upper_nz  = 1'b0;
`endif
    if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      // Snapshot only at slot start so a slot never shows two different values.
      if (cnt_q == '0) begin
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
          if (idx_q == IW'(k)) begin
            cur_nib_d = digits[4*k +: 4];
            cur_dp_d  = dp[k];
          end
`ifdef LEADING_ZERO_BLANK_EN
          if (k >= 32'(idx_q)) upper_nz = upper_nz | (|digits[4*k +: 4]);
`endif
        end
`ifdef LEADING_ZERO_BLANK_EN
        lz_d = (idx_q != '0) && !upper_nz;
`endif
      end
    end
  end

  always_comb begin
    case (cur_nib_q)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      default: seg_dec = 7'h0E;
    endcase
  end

  always_comb begin
    an_d   = '1;
    seg_d  = '1;
    dp_ld  = 1'b1;
    didx_d = idx_q;
    if (en && (cnt_q != '0)) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        an_d[k] = (idx_q != IW'(k));
      end
      seg_d = seg_dec;
      dp_ld = ~cur_dp_q;
`ifdef LEADING_ZERO_BLANK_EN
      if (lz_q) seg_d = '1;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      an_L      <= '1;
      seg_L     <= '1;
      dp_L      <= 1'b1;
      digit_idx <= '0;
    end else begin
      an_L      <= an_d;
      seg_L     <= seg_d;
      dp_L      <= dp_ld;
      digit_idx <= didx_d;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with NUM_DIGITS=4, SCAN_DIV=4.
module tb_display_scanner;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [6:0]  seg_L;
  logic        dp_L;
  logic [3:0]  an_L;
  logic [1:0]  digit_idx;

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;

  always #5 clock = ~clock;

  display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clock(clock), .reset(reset), .en(en), .digits(digits), .dp(dp),
    .seg_L(seg_L), .dp_L(dp_L), .an_L(an_L), .digit_idx(digit_idx)
  );

  // At most one anode may be low on every cycle.
  always @(negedge clock) begin
    if (mon_on) begin
      logic ok;
      ok = ($countones(~an_L) <= 1);
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL onehot an_L got %b want at most one low bit", an_L);
      end
    end
  end

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic restart(input logic [15:0] d, input logic [3:0] p);
    reset = 1'b1; en = 1'b1; digits = d; dp = p;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b1; digits = 16'h1234; dp = 4'hF;
    tick;
    tick;
    mon_on = 1'b1;
    checks++; if (an_L !== 4'hF) begin errors++; $display("FAIL reset_an got %b want 1111", an_L); end
    checks++; if (seg_L !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", seg_L); end
    checks++; if (dp_L !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp_L); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", digit_idx); end
  endtask

  task automatic test_scan;
    logic [15:0] v;
    logic [3:0]  p;
    logic [3:0]  exp_an;
    logic [1:0]  dd;
    v = 16'h1234; p = 4'b0101;
    restart(v, p);
    for (int t = 0; t < 20; t++) begin
      tick;
      dd = 2'((t / 4) % 4);
      checks++;
      if (digit_idx !== dd) begin errors++; $display("FAIL scan_idx t=%0d got %0d want %0d", t, digit_idx, dd); end
      if (t % 4 == 0) begin
        checks++;
        if (an_L !== 4'hF) begin errors++; $display("FAIL scan_blank t=%0d got %b want 1111", t, an_L); end
      end else begin
        exp_an = ~(4'b0001 << dd);
        checks++;
        if (an_L !== exp_an) begin errors++; $display("FAIL scan_an t=%0d got %b want %b", t, an_L, exp_an); end
        checks++;
        if (seg_L !== seg_ref(v[4*dd +: 4])) begin
          errors++; $display("FAIL scan_seg t=%0d got %h want %h", t, seg_L, seg_ref(v[4*dd +: 4]));
        end
        checks++;
        if (dp_L !== ~p[dd]) begin errors++; $display("FAIL scan_dp t=%0d got %b want %b", t, dp_L, ~p[dd]); end
      end
    end
  endtask

  task automatic test_tearing;
    logic [23:0] seq;
    logic [3:0]  nib;
    logic [1:0]  dd;
    int          s;
    seq = 24'h785634;  // per-slot shown nibble, slot 0 in the low nibble
    restart(16'h1234, 4'b0000);
    for (int t = 0; t < 24; t++) begin
      tick;
      if (t == 5) digits = 16'h5678;
      s  = t / 4;
      dd = 2'(s % 4);
      nib = seq[4*s +: 4];
      if (t % 4 != 0) begin
        checks++;
        if (seg_L !== seg_ref(nib)) begin errors++; $display("FAIL tear_seg t=%0d got %h want %h", t, seg_L, seg_ref(nib)); end
        checks++;
        if (an_L !== ~(4'b0001 << dd)) begin errors++; $display("FAIL tear_an t=%0d got %b want %b", t, an_L, ~(4'b0001 << dd)); end
      end
    end
  endtask

  task automatic test_en_toggle;
    restart(16'h1234, 4'b0000);
    repeat (6) tick;
    en = 1'b0;
    digits = 16'h5678;
    for (int t = 0; t < 10; t++) begin
      tick;
      checks++;
      if (an_L !== 4'hF || seg_L !== 7'h7F || dp_L !== 1'b1 || digit_idx !== 2'd1) begin
        errors++;
        $display("FAIL en_dark t=%0d got an=%b seg=%h dp=%b idx=%0d want an=1111 seg=7f dp=1 idx=1",
                 t, an_L, seg_L, dp_L, digit_idx);
      end
    end
    en = 1'b1;
    for (int t = 0; t < 2; t++) begin
      tick;
      checks++;
      if (an_L !== 4'b1101 || seg_L !== 7'h30 || digit_idx !== 2'd1) begin
        errors++;
        $display("FAIL en_resume t=%0d got an=%b seg=%h idx=%0d want an=1101 seg=30 idx=1",
                 t, an_L, seg_L, digit_idx);
      end
    end
    tick;
    checks++;
    if (an_L !== 4'hF || digit_idx !== 2'd2) begin
      errors++; $display("FAIL en_next_blank got an=%b idx=%0d want an=1111 idx=2", an_L, digit_idx);
    end
    for (int t = 0; t < 3; t++) begin
      tick;
      checks++;
      if (an_L !== 4'b1011 || seg_L !== 7'h02) begin
        errors++; $display("FAIL en_next_digit t=%0d got an=%b seg=%h want an=1011 seg=02", t, an_L, seg_L);
      end
    end
  endtask

  task automatic test_reset_mid;
    restart(16'h1234, 4'b0000);
    repeat (10) tick;
    checks++;
    if (an_L !== 4'b1011 || digit_idx !== 2'd2) begin
      errors++; $display("FAIL rmid_pre got an=%b idx=%0d want an=1011 idx=2", an_L, digit_idx);
    end
    reset = 1'b1;
    tick;
    checks++;
    if (an_L !== 4'hF || seg_L !== 7'h7F || dp_L !== 1'b1 || digit_idx !== 2'd0) begin
      errors++;
      $display("FAIL rmid_reset got an=%b seg=%h dp=%b idx=%0d want an=1111 seg=7f dp=1 idx=0",
               an_L, seg_L, dp_L, digit_idx);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (an_L !== 4'hF || digit_idx !== 2'd0) begin
      errors++; $display("FAIL rmid_blank got an=%b idx=%0d want an=1111 idx=0", an_L, digit_idx);
    end
    for (int t = 0; t < 3; t++) begin
      tick;
      checks++;
      if (an_L !== 4'b1110 || seg_L !== 7'h19 || digit_idx !== 2'd0) begin
        errors++;
        $display("FAIL rmid_digit0 t=%0d got an=%b seg=%h idx=%0d want an=1110 seg=19 idx=0",
                 t, an_L, seg_L, digit_idx);
      end
    end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  logic [6:0] lz70_seg [4] = '{7'h40, 7'h78, 7'h7F, 7'h7F};
  logic [6:0] lz00_seg [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
`else
  logic [6:0] lz70_seg [4] = '{7'h40, 7'h78, 7'h40, 7'h40};
  logic [6:0] lz00_seg [4] = '{7'h40, 7'h40, 7'h40, 7'h40};
`endif
  logic       lz70_dpl [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  task automatic test_leading_zero;
    int d;
    restart(16'h0070, 4'b0100);
    for (int t = 0; t < 16; t++) begin
      tick;
      d = (t / 4) % 4;
      if (t % 4 != 0) begin
        checks++;
        if (seg_L !== lz70_seg[d] || dp_L !== lz70_dpl[d] || an_L !== ~(4'b0001 << d)) begin
          errors++;
          $display("FAIL lz70 t=%0d got seg=%h dp=%b an=%b want seg=%h dp=%b an=%b",
                   t, seg_L, dp_L, an_L, lz70_seg[d], lz70_dpl[d], ~(4'b0001 << d));
        end
      end
    end
    restart(16'h0000, 4'b0000);
    for (int t = 0; t < 16; t++) begin
      tick;
      d = (t / 4) % 4;
      if (t % 4 != 0) begin
        checks++;
        if (seg_L !== lz00_seg[d] || an_L !== ~(4'b0001 << d)) begin
          errors++;
          $display("FAIL lz00 t=%0d got seg=%h an=%b want seg=%h an=%b",
                   t, seg_L, an_L, lz00_seg[d], ~(4'b0001 << d));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; digits = '0; dp = '0;
    test_reset;
    test_scan;
    test_tearing;
    test_en_toggle;
    test_reset_mid;
    test_leading_zero;
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
